seven_segment_scan_decoder: RTL and testbench

- Receive-side counterpart of the team's hex-to-seven-segment encoder.
- Monitors a time-multiplexed seven-segment display bus (segment lines plus one-hot digit enables), e.g. from the display driver or an external board under test.
- Debounces each digit slot, decodes the segment pattern back to a 4-bit hex nibble, and assembles a DIGITS-nibble word.
- Used for self-check and loopback of the display path in the multicycle MIPS debug setup.

---
 rtl/seven_segment_scan_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder
//
// Watches a time-multiplexed seven-segment display bus and turns it back into
// hex nibbles. Each {dig_en, seg_in} combination has to stay put for
// STABLE_CYCLES edges before it is committed. A commit decodes the segment
// pattern into the nibble slot selected by the one-hot digit enable.
// frame_done pulses once every digit has been committed since the previous
// pulse.
//
// Parameters:
//   DIGITS         number of multiplexed digits (value_out is 4*DIGITS wide)
//   STABLE_CYCLES  edges the bus must hold unchanged before a capture (>= 2)
//   ACTIVE_LOW_SEG 1 = segment lines are active low and are inverted before decode
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   seg_in       segment lines {g,f,e,d,c,b,a}
//   dig_en       digit enables, active high, one-hot or zero
//   err_clr      clears the sticky error flag
//   value_out    decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  bit i set while nibble i holds a validly decoded pattern
//   frame_done   one-cycle pulse after every digit has been captured
//   error        sticky: invalid pattern or multi-hot dig_en committed

module seven_segment_scan_decoder #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  error
);

  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CYCLES - 1);

  typedef enum logic {COLLECT = 1'b0} frame_state_t;

  // Returns {valid, nibble} for a segment pattern (bit 0 = a, bit 6 = g).
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Sampling / stability counter
  // ---------------------------------------------------------------------------
  logic [SW-1:0]     sample_in;
  logic [SW-1:0]     s_reg;
  logic [CW-1:0]     cnt_reg;
  logic              same;
  logic              commit;

  assign sample_in = {dig_en, seg_in};
  assign same      = (sample_in == s_reg);
  // cnt saturates at STABLE_CYCLES, so the commit value is passed only once per
  // stable period.
  assign commit    = same && (cnt_reg == CNT_COMMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg   <= '0;
      cnt_reg <= '0;
    end else begin
      s_reg <= sample_in;
      if (!same) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Classification of the committed sample. At a commit the live input equals
  // s_reg, so the registered copy is decoded to keep input pins off the path.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] s_dig;
  logic [6:0]        s_seg;
  logic [6:0]        seg_eff;
  logic [4:0]        dec;
  logic              pat_valid;
  logic [3:0]        pat_nibble;
  logic              dig_zero;
  logic              dig_multi;
  logic              dig_onehot;
  logic              commit_onehot;
  logic              error_set;

  assign s_dig      = s_reg[SW-1:7];
  assign s_seg      = s_reg[6:0];
  assign seg_eff    = ACTIVE_LOW_SEG ? ~s_seg : s_seg;
  assign dec        = decode(seg_eff);
  assign pat_valid  = dec[4];
  assign pat_nibble = dec[3:0];

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign dig_zero      = (s_dig == '0);
  assign dig_multi     = ((s_dig & (s_dig - 1'b1)) != '0);
  assign dig_onehot    = !dig_zero && !dig_multi;
  assign commit_onehot = commit && dig_onehot;
  assign error_set     = commit && (dig_multi || (dig_onehot && !pat_valid));

  // ---------------------------------------------------------------------------
  // Per-digit nibble and valid storage
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] nibble_reg;
      logic       valid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          nibble_reg <= '0;
          valid_reg  <= 1'b0;
        end else if (commit_onehot && s_dig[gi]) begin
          // An invalid pattern keeps the old nibble but drops its valid flag.
          valid_reg <= pat_valid;
          if (pat_valid) begin
            nibble_reg <= pat_nibble;
          end
        end
      end

      assign value_out[4*gi +: 4] = nibble_reg;
      assign digit_valid[gi]      = valid_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame tracking FSM
  // ---------------------------------------------------------------------------
  frame_state_t      state_reg;
  frame_state_t      state_next;
  logic [DIGITS-1:0] seen_mask_reg;
  logic [DIGITS-1:0] seen_mask_next;
  logic [DIGITS-1:0] seen_merged;
  logic              frame_done_reg;
  logic              frame_done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= COLLECT;
      seen_mask_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      seen_mask_reg  <= seen_mask_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    seen_mask_next  = seen_mask_reg;
    frame_done_next = 1'b0;
    seen_merged     = seen_mask_reg | s_dig;
    case (state_reg)
      COLLECT: begin
        if (commit_onehot) begin
          // Completing the set emits the pulse and starts the next frame empty.
          if (seen_merged == {DIGITS{1'b1}}) begin
            seen_mask_next  = '0;
            frame_done_next = 1'b1;
          end else begin
            seen_mask_next = seen_merged;
          end
        end
      end
      default: begin
        seen_mask_next  = '0;
        frame_done_next = 1'b0;
      end
    endcase
  end

  assign frame_done = frame_done_reg;

  // ---------------------------------------------------------------------------
  // Sticky error: a new error wins over a simultaneous clear.
  // ---------------------------------------------------------------------------
  logic error_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      error_reg <= 1'b0;
    end else if (error_set) begin
      error_reg <= 1'b1;
    end else if (err_clr) begin
      error_reg <= 1'b0;
    end
  end

  assign error = error_reg;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed testbench for seven_segment_scan_decoder. A second instance built
// with ACTIVE_LOW_SEG=1 receives the same stimulus with inverted segment lines.
// Its results must match those of the first instance.

module tb_seven_segment_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [6:0]  seg_al = 7'h7F;
  logic [3:0]  dig_en = '0;
  logic        err_clr = 1'b0;

  logic [15:0] value_out, value_al;
  logic [3:0]  digit_valid, valid_al;
  logic        frame_done, frame_al;
  logic        error, error_al;

  int errors = 0;
  int checks = 0;
  int frame_cnt = 0;
  int frame_cnt_al = 0;

  localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F;
  localparam logic [6:0] P4 = 7'h66, P5 = 7'h6D, P6 = 7'h7D, P8 = 7'h7F;
  localparam logic [6:0] P9 = 7'h6F, PA = 7'h77, PB = 7'h7C, PC = 7'h39;
  localparam logic [6:0] PD = 7'h5E, PE = 7'h79, PF = 7'h71;

  always #5 clk = ~clk;

  seven_segment_scan_decoder #(
    .DIGITS(4), .STABLE_CYCLES(4), .ACTIVE_LOW_SEG(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en), .err_clr(err_clr),
    .value_out(value_out), .digit_valid(digit_valid), .frame_done(frame_done),
    .error(error)
  );

  seven_segment_scan_decoder #(
    .DIGITS(4), .STABLE_CYCLES(4), .ACTIVE_LOW_SEG(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .seg_in(seg_al), .dig_en(dig_en), .err_clr(err_clr),
    .value_out(value_al), .digit_valid(valid_al), .frame_done(frame_al),
    .error(error_al)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_done) frame_cnt++;
    if (frame_al)   frame_cnt_al++;
  end

  // Present {d, s} for n rising edges, then return 1 time unit past the last edge.
  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    dig_en = d;
    seg_in = s;
    seg_al = ~s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dig_en = 4'($urandom);
      seg_in = 7'($urandom);
      seg_al = ~seg_in;
      err_clr = 1'($urandom);
      @(posedge clk);
    end
    #1;
    err_clr = 1'b0;
    checks++; if (value_out !== 16'h0) begin errors++; $display("FAIL reset_value: got %h want 0000", value_out); end
    checks++; if (digit_valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b want 0000", digit_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", frame_done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if ({value_al, valid_al, frame_al, error_al} !== 22'h0) begin errors++; $display("FAIL reset_al: got %h/%b/%b/%b want all 0", value_al, valid_al, frame_al, error_al); end
    rst = 1'b0;
    hold(4'b0000, P0, 2);
    $display("reset: value=%h valid=%b error=%b", value_out, digit_valid, error);
  endtask

  task automatic test_scan_frame();
    int base;
    base = frame_cnt;
    hold(4'b0001, P1, 6);
    hold(4'b0010, P2, 6);
    hold(4'b0100, P3, 6);
    // Commit lands on the 5th edge; its frame pulse is visible right after it.
    hold(4'b1000, P4, 5);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL scan_frame_pulse: got %b want 1", frame_done); end
    checks++; if (value_out !== 16'h4321) begin errors++; $display("FAIL scan_value: got %h want 4321", value_out); end
    checks++; if (digit_valid !== 4'b1111) begin errors++; $display("FAIL scan_valid: got %b want 1111", digit_valid); end
    hold(4'b1000, P4, 1);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL scan_pulse_width: got %b want 0", frame_done); end
    hold(4'b1000, P4, 3);
    checks++; if (frame_cnt - base !== 1) begin errors++; $display("FAIL scan_frame_count: got %0d want 1", frame_cnt - base); end
    $display("scan: value=%h valid=%b frames=%0d", value_out, digit_valid, frame_cnt - base);
  endtask

  task automatic test_debounce();
    int base;
    base = frame_cnt;
    hold(4'b0001, P5, 3);
    hold(4'b0001, P5, 0);
    checks++; if (value_out !== 16'h4321) begin errors++; $display("FAIL debounce_short: got %h want 4321", value_out); end
    hold(4'b0001, P6, 6);
    checks++; if (value_out !== 16'h4326) begin errors++; $display("FAIL debounce_capture: got %h want 4326", value_out); end
    checks++; if (frame_cnt - base !== 0) begin errors++; $display("FAIL debounce_frame: got %0d want 0", frame_cnt - base); end
    $display("debounce: value=%h", value_out);
  endtask

  task automatic test_invalid_pattern();
    hold(4'b0100, 7'b0000001, 6);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL invalid_error: got %b want 1", error); end
    checks++; if (digit_valid !== 4'b1011) begin errors++; $display("FAIL invalid_valid: got %b want 1011", digit_valid); end
    checks++; if (value_out !== 16'h4326) begin errors++; $display("FAIL invalid_nibble: got %h want 4326", value_out); end
    err_clr = 1'b1;
    hold(4'b0100, 7'b0000001, 1);
    err_clr = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL invalid_err_clr: got %b want 0", error); end
    hold(4'b0100, 7'b0000001, 2);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL invalid_no_recommit: got %b want 0", error); end
    $display("invalid: value=%h valid=%b error=%b", value_out, digit_valid, error);
  endtask

  task automatic test_multi_hot();
    int base;
    base = frame_cnt;
    hold(4'b0110, P8, 6);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL multi_error: got %b want 1", error); end
    checks++; if (value_out !== 16'h4326) begin errors++; $display("FAIL multi_value: got %h want 4326", value_out); end
    checks++; if (digit_valid !== 4'b1011) begin errors++; $display("FAIL multi_valid: got %b want 1011", digit_valid); end
    checks++; if (frame_cnt - base !== 0) begin errors++; $display("FAIL multi_frame: got %0d want 0", frame_cnt - base); end
    // Blanking with a clear pending: no new error, so the clear takes effect.
    err_clr = 1'b1;
    hold(4'b0000, P8, 6);
    err_clr = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL blank_clear: got %b want 0", error); end
    $display("multi_hot: value=%h valid=%b error=%b", value_out, digit_valid, error);
  endtask

  task automatic test_reset_mid_frame();
    int base, base_al;
    hold(4'b0001, P9, 6);
    hold(4'b0010, PA, 6);
    hold(4'b0100, PB, 6);
    checks++; if (value_out !== 16'h4BA9) begin errors++; $display("FAIL midframe_value: got %h want 4ba9", value_out); end
    rst = 1'b1;
    hold(4'b0100, PB, 1);
    rst = 1'b0;
    checks++; if ({value_out, digit_valid, error} !== 21'h0) begin errors++; $display("FAIL midframe_reset: got %h/%b/%b want 0", value_out, digit_valid, error); end
    base = frame_cnt;
    base_al = frame_cnt_al;
    hold(4'b1000, PF, 6);
    hold(4'b0001, PC, 6);
    hold(4'b0010, PD, 6);
    checks++; if (frame_cnt - base !== 0) begin errors++; $display("FAIL midframe_early: got %0d want 0", frame_cnt - base); end
    hold(4'b0100, PE, 6);
    hold(4'b0000, P0, 2);
    checks++; if (frame_cnt - base !== 1) begin errors++; $display("FAIL midframe_frame: got %0d want 1", frame_cnt - base); end
    checks++; if (value_out !== 16'hFEDC) begin errors++; $display("FAIL midframe_rescan: got %h want fedc", value_out); end
    checks++; if (digit_valid !== 4'b1111) begin errors++; $display("FAIL midframe_valid: got %b want 1111", digit_valid); end
    checks++; if (value_al !== 16'hFEDC) begin errors++; $display("FAIL al_value: got %h want fedc", value_al); end
    checks++; if (valid_al !== 4'b1111) begin errors++; $display("FAIL al_valid: got %b want 1111", valid_al); end
    checks++; if (error_al !== 1'b0) begin errors++; $display("FAIL al_error: got %b want 0", error_al); end
    checks++; if (frame_cnt_al - base_al !== 1) begin errors++; $display("FAIL al_frame: got %0d want 1", frame_cnt_al - base_al); end
    $display("reset_mid_frame: value=%h valid=%b frames=%0d al_value=%h", value_out, digit_valid, frame_cnt - base, value_al);
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_scan_frame();
    test_debounce();
    test_invalid_pattern();
    test_multi_hot();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
